roi_crop: RTL

- Generalised region-of-interest cropper on the imager pixel stream (dvi/datai/dtypei/meta_datai).
- Two placement modes:
  - center mode: the window is centered using input dimensions measured on the previous frame.
  - explicit mode: the window is placed at a programmable row/col start.
- Configuration is shadow-latched at frame start so mid-frame register writes never tear a frame.
- Image header num_rows/num_cols fields are rewritten to the effective output size. Sits between the sensor front end and downstream ISP blocks.

---
 rtl/roi_crop_pkg.sv | 19 +
 rtl/roi_window_calc.sv | 96 +++++++++
 rtl/roi_crop.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/roi_crop_pkg.sv
// Shared stream tags and header layout for the region-of-interest cropper.
package roi_crop_pkg;

   localparam int DTYPE_WIDTH = 8;

   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 8'h01;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 8'h02;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 8'h04;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 8'h08;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 8'h10;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 8'h20;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 8'h40;
   localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 8'hC0;

   // Word offsets of the dimension fields within the image header.
   localparam int IMAGE_NUM_ROWS = 2;
   localparam int IMAGE_NUM_COLS = 3;

endpackage

// File: rtl/roi_window_calc.sv
// Registered crop-window calculator: turns a latched request plus measured input
// dimensions into start/size per axis and a clip flag. Updates only on load.
module roi_window_calc #(
   parameter int DIM_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 clear,
   input  logic                 load,
   input  logic                 center_mode,
   input  logic [DIM_WIDTH-1:0] row_start,
   input  logic [DIM_WIDTH-1:0] col_start,
   input  logic [DIM_WIDTH-1:0] num_rows,
   input  logic [DIM_WIDTH-1:0] num_cols,
   input  logic [DIM_WIDTH-1:0] meas_rows,
   input  logic [DIM_WIDTH-1:0] meas_cols,
   output logic [DIM_WIDTH-1:0] rs,
   output logic [DIM_WIDTH-1:0] cs,
   output logic [DIM_WIDTH-1:0] rn,
   output logic [DIM_WIDTH-1:0] cn,
   output logic                 pass_all,
   output logic                 clamped
);

   logic [1:0][DIM_WIDTH-1:0] meas_a, req_a, start_a, st_c, sz_c;
   logic [1:0]                clip_c;
   logic                      no_meas;

   assign meas_a  = {meas_cols, meas_rows};
   assign req_a   = {num_cols, num_rows};
   assign start_a = {col_start, row_start};
   assign no_meas = (meas_rows == '0) || (meas_cols == '0);

   // Axis 0 = rows, axis 1 = cols; identical clipping arithmetic on each.
   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      logic [DIM_WIDTH:0]   meas_x, req_x, start_x, avail_x;
      logic [DIM_WIDTH-1:0] fit, ctr, start, avail, size;
      logic                 over, clip;

      always_comb begin
         meas_x  = {1'b0, meas_a[gi]};
         req_x   = {1'b0, req_a[gi]};
         over    = req_x > meas_x;
         fit     = over ? meas_a[gi] : req_a[gi];
         ctr     = (meas_a[gi] - fit) >> 1;
         start   = center_mode ? ctr : start_a[gi];
         start_x = {1'b0, start};
         avail   = meas_a[gi] - start;
         avail_x = {1'b0, avail};
         size    = req_a[gi];
         clip    = 1'b0;
         if (start_x >= meas_x) begin
            size = '0;
            clip = 1'b1;
         end else if (req_x > avail_x) begin
            size = avail;
            clip = 1'b1;
         end
      end

      assign st_c[gi]   = start;
      assign sz_c[gi]   = size;
      assign clip_c[gi] = clip;
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rs       <= '0;
         cs       <= '0;
         rn       <= '0;
         cn       <= '0;
         pass_all <= 1'b0;
         clamped  <= 1'b0;
      end else if (load) begin
         if (no_meas) begin
            // No prior frame measured: center mode passes everything untouched.
            pass_all <= center_mode;
            rs       <= center_mode ? '0 : row_start;
            cs       <= center_mode ? '0 : col_start;
            rn       <= center_mode ? '1 : num_rows;
            cn       <= center_mode ? '1 : num_cols;
            clamped  <= 1'b0;
         end else begin
            pass_all <= 1'b0;
            rs       <= st_c[0];
            cs       <= st_c[1];
            rn       <= sz_c[0];
            cn       <= sz_c[1];
            clamped  <= |clip_c;
         end
      end else if (clear) begin
         clamped <= 1'b0;
      end
   end

endmodule

// File: rtl/roi_crop.sv
// Region-of-interest cropper on the imager stream: suppresses beats outside the
// window latched at frame start and rewrites header dimensions to the output size.
module roi_crop
   import roi_crop_pkg::*;
#(
   parameter int PIXEL_WIDTH    = 10,
   parameter int DIM_WIDTH      = 12,
   parameter int META_WIDTH     = 16,
   parameter int HDR_ADDR_WIDTH = 6
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   enable,
   input  logic                   center_mode,
   input  logic [DIM_WIDTH-1:0]   row_start,
   input  logic [DIM_WIDTH-1:0]   col_start,
   input  logic [DIM_WIDTH-1:0]   num_output_rows,
   input  logic [DIM_WIDTH-1:0]   num_output_cols,
   input  logic                   dvi,
   input  logic [PIXEL_WIDTH-1:0] datai,
   input  logic [DTYPE_WIDTH-1:0] dtypei,
   input  logic [META_WIDTH-1:0]  meta_datai,
   output logic                   dvo,
   output logic [PIXEL_WIDTH-1:0] datao,
   output logic [DTYPE_WIDTH-1:0] dtypeo,
   output logic [META_WIDTH-1:0]  meta_datao,
   output logic                   clamped
);

   logic is_fs, is_fe, is_rs, is_re, is_hs, is_hdr, is_pix;
   logic [DIM_WIDTH-1:0] row_reg, col_reg, meas_rows_reg, meas_cols_reg;
   logic                 sh_center_reg, load_reg;
   logic [DIM_WIDTH-1:0] sh_row_start_reg, sh_col_start_reg, sh_rows_reg, sh_cols_reg;
   logic [HDR_ADDR_WIDTH-1:0] hdr_addr_reg;
   logic [DIM_WIDTH-1:0] win_rs, win_cs, win_rn, win_cn;
   logic                 win_pass_all, row_valid, col_valid, suppress;
   logic [META_WIDTH-1:0] meta_next;
   logic                  dvo_reg;
   logic [PIXEL_WIDTH-1:0] datao_reg;
   logic [DTYPE_WIDTH-1:0] dtypeo_reg;
   logic [META_WIDTH-1:0]  meta_datao_reg;

   assign is_fs  = dvi && (dtypei == DTYPE_FRAME_START);
   assign is_fe  = dvi && (dtypei == DTYPE_FRAME_END);
   assign is_rs  = dvi && (dtypei == DTYPE_ROW_START);
   assign is_re  = dvi && (dtypei == DTYPE_ROW_END);
   assign is_hs  = dvi && (dtypei == DTYPE_HEADER_START);
   assign is_hdr = dvi && (dtypei == DTYPE_HEADER);
   assign is_pix = dvi && |(dtypei & DTYPE_PIXEL_MASK);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         row_reg          <= '0;
         col_reg          <= '0;
         meas_rows_reg    <= '0;
         meas_cols_reg    <= '0;
         sh_center_reg    <= 1'b0;
         sh_row_start_reg <= '0;
         sh_col_start_reg <= '0;
         sh_rows_reg      <= '0;
         sh_cols_reg      <= '0;
         load_reg         <= 1'b0;
         hdr_addr_reg     <= '0;
      end else begin
         if (is_fs) begin
            row_reg <= '0;
            col_reg <= '0;
         end else if (is_re) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
         end else if (is_pix) begin
            col_reg <= col_reg + 1'b1;
         end

         if (!enable) begin
            meas_rows_reg <= '0;
            meas_cols_reg <= '0;
         end else begin
            if (is_re) meas_cols_reg <= col_reg;
            if (is_fe) meas_rows_reg <= row_reg;
         end

         // Shadow copy keeps mid-frame register writes out of the current frame.
         load_reg <= enable && is_fs;
         if (enable && is_fs) begin
            sh_center_reg    <= center_mode;
            sh_row_start_reg <= row_start;
            sh_col_start_reg <= col_start;
            sh_rows_reg      <= num_output_rows;
            sh_cols_reg      <= num_output_cols;
         end

         if (is_hs)       hdr_addr_reg <= '0;
         else if (is_hdr) hdr_addr_reg <= hdr_addr_reg + 1'b1;
      end
   end

   roi_window_calc #(
      .DIM_WIDTH (DIM_WIDTH)
   ) u_window_calc (
      .clk         (clk),
      .resetb      (resetb),
      .clear       (enable && is_fs),
      .load        (load_reg),
      .center_mode (sh_center_reg),
      .row_start   (sh_row_start_reg),
      .col_start   (sh_col_start_reg),
      .num_rows    (sh_rows_reg),
      .num_cols    (sh_cols_reg),
      .meas_rows   (meas_rows_reg),
      .meas_cols   (meas_cols_reg),
      .rs          (win_rs),
      .cs          (win_cs),
      .rn          (win_rn),
      .cn          (win_cn),
      .pass_all    (win_pass_all),
      .clamped     (clamped)
   );

   assign row_valid = win_pass_all ||
                      (({1'b0, row_reg} >= {1'b0, win_rs}) &&
                       ({1'b0, row_reg} <  ({1'b0, win_rs} + {1'b0, win_rn})));
   assign col_valid = win_pass_all ||
                      (({1'b0, col_reg} >= {1'b0, win_cs}) &&
                       ({1'b0, col_reg} <  ({1'b0, win_cs} + {1'b0, win_cn})));

   always_comb begin
      suppress  = 1'b0;
      meta_next = meta_datai;
      if (enable && dvi) begin
         if (is_pix && !(row_valid && col_valid)) suppress = 1'b1;
         if ((is_rs || is_re) && !row_valid)     suppress = 1'b1;
         if (is_hdr && !win_pass_all) begin
            if (hdr_addr_reg == HDR_ADDR_WIDTH'(IMAGE_NUM_COLS))
               meta_next = META_WIDTH'(win_cn);
            else if (hdr_addr_reg == HDR_ADDR_WIDTH'(IMAGE_NUM_ROWS))
               meta_next = META_WIDTH'(win_rn);
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         dvo_reg        <= 1'b0;
         datao_reg      <= '0;
         dtypeo_reg     <= '0;
         meta_datao_reg <= '0;
      end else begin
         dvo_reg        <= dvi && !suppress;
         datao_reg      <= datai;
         dtypeo_reg     <= suppress ? '0 : dtypei;
         meta_datao_reg <= meta_next;
      end
   end

   assign dvo        = dvo_reg;
   assign datao      = datao_reg;
   assign dtypeo     = dtypeo_reg;
   assign meta_datao = meta_datao_reg;

endmodule
